// File: rtl/cpu_mem_pkg.sv
// Shared control-bundle layout, size/source encodings and FSM states for the
// memory-access stage. The control bundle is a flat vector so it can ride the
// pipeline latches unchanged; field positions are named here.
package cpu_mem_pkg;

   localparam int CON_LSB = 0;
   localparam int CON_MSB = 6;

   typedef logic [CON_MSB:CON_LSB] con_t;

   // Bit positions inside the control bundle
   localparam int CON_MEM_READ          = 0;
   localparam int CON_MEM_WRITE         = 1;
   localparam int CON_MEM_SIZE_LSB      = 2;
   localparam int CON_MEM_SIZE_MSB      = 3;
   localparam int CON_MEM_SIGN          = 4;
   localparam int CON_REG_WRITE_SRC_LSB = 5;
   localparam int CON_REG_WRITE_SRC_MSB = 6;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   localparam logic [1:0] REG_WRITE_SRC_ALU  = 2'd0;
   localparam logic [1:0] REG_WRITE_SRC_MEM  = 2'd1;
   localparam logic [1:0] REG_WRITE_SRC_LINK = 2'd2;

   localparam con_t CON_NOP = '0;

   typedef enum logic [1:0] {
      MEM_STATE_IDLE  = 2'd0,
      MEM_STATE_WAIT  = 2'd1,
      MEM_STATE_ABORT = 2'd2
   } mem_state_e;

   // Assemble a control bundle from its fields
   function automatic con_t mk_con(input logic rd, input logic wr,
                                   input logic [1:0] size, input logic sgn,
                                   input logic [1:0] src);
      con_t c;
      c = CON_NOP;
      c[CON_MEM_READ]  = rd;
      c[CON_MEM_WRITE] = wr;
      c[CON_MEM_SIZE_MSB:CON_MEM_SIZE_LSB] = size;
      c[CON_MEM_SIGN]  = sgn;
      c[CON_REG_WRITE_SRC_MSB:CON_REG_WRITE_SRC_LSB] = src;
      return c;
   endfunction

endpackage

// File: rtl/cpu_mem_lane.sv
// Byte-lane steering for data-memory accesses: store byte enables and
// replicated write data, load extraction with sign/zero extension, and the
// alignment check. Purely combinational.
module mem_lane_unit
   import cpu_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o,
   output logic        aligned_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed byte and half out of the read word
   always_comb begin
      byte_v = rdata_i[7:0];
      case (addr_lo_i)
         2'd0: byte_v = rdata_i[7:0];
         2'd1: byte_v = rdata_i[15:8];
         2'd2: byte_v = rdata_i[23:16];
         2'd3: byte_v = rdata_i[31:24];
         default: byte_v = rdata_i[7:0];
      endcase
      half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Size-dependent enables, store replication, load extension and alignment
   always_comb begin
      be_o      = 4'b1111;
      wdata_o   = st_data_i;
      load_o    = rdata_i;
      aligned_o = (addr_lo_i == 2'b00);
      case (size_i)
         MEM_SIZE_B: begin
            be_o      = 4'b0001 << addr_lo_i;
            wdata_o   = {4{st_data_i[7:0]}};
            load_o    = sign_i ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            aligned_o = 1'b1;
         end
         MEM_SIZE_H: begin
            be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o   = {2{st_data_i[15:0]}};
            load_o    = sign_i ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            aligned_o = ~addr_lo_i[0];
         end
         default: begin
            be_o      = 4'b1111;
            wdata_o   = st_data_i;
            load_o    = rdata_i;
            aligned_o = (addr_lo_i == 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/cpu_mem.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack port, stalls
// upstream while an access is outstanding, aborts after TIMEOUT wait cycles,
// and latches the selected write-back value (ALU, load data or link) for WB.
module cpu_mem
   import cpu_mem_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic [31:0]          current_pc_ex,
   input  logic [31:0]          ins_ex,
   input  logic [CON_MSB:CON_LSB] controls_ex,
   input  logic [31:0]          reg_read2_data_ex,
   input  logic [31:0]          alu_result,
   input  logic                 reg_write_en,
   input  logic [4:0]           reg_write_num,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [31:0]          dmem_addr,
   output logic [3:0]           dmem_be,
   output logic [31:0]          dmem_wdata,
   input  logic [31:0]          dmem_rdata,
   input  logic                 dmem_ack,
   output logic                 mem_stall,
   output logic [31:0]          current_pc_mem,
   output logic [31:0]          ins_mem,
   output logic [CON_MSB:CON_LSB] controls_mem,
   output logic [31:0]          reg_write_data_mem,
   output logic                 reg_write_en_mem,
   output logic [4:0]           reg_write_num_mem,
   output logic [4:0]           reg_write_num_realtime,
   output logic [31:0]          reg_write_data_realtime,
   output logic                 mem_align_err,
   output logic                 mem_bus_err
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   mem_state_e  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        mem_rd, mem_wr, mem_op, mem_sign, aligned;
   logic [1:0]  mem_size, wb_src;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_val, wb_val;
   logic        issue, misalign, bubble_sel;

   assign mem_rd   = controls_ex[CON_MEM_READ];
   assign mem_wr   = controls_ex[CON_MEM_WRITE];
   assign mem_op   = mem_rd | mem_wr;
   assign mem_sign = controls_ex[CON_MEM_SIGN];
   assign mem_size = controls_ex[CON_MEM_SIZE_MSB:CON_MEM_SIZE_LSB];
   assign wb_src   = controls_ex[CON_REG_WRITE_SRC_MSB:CON_REG_WRITE_SRC_LSB];

   mem_lane_unit u_lane (
      .size_i    (mem_size),
      .sign_i    (mem_sign),
      .addr_lo_i (alu_result[1:0]),
      .st_data_i (reg_read2_data_ex),
      .rdata_i   (dmem_rdata),
      .be_o      (lane_be),
      .wdata_o   (lane_wdata),
      .load_o    (load_val),
      .aligned_o (aligned)
   );

   // A new access may only start from IDLE; reset kills the request at once
   assign issue    = clr_n & (state_q == MEM_STATE_IDLE) & mem_op & aligned;
   assign misalign = (state_q == MEM_STATE_IDLE) & mem_op & ~aligned;

   // FSM state and wait counter registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= MEM_STATE_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: ack beats timeout when both land in the same cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         MEM_STATE_IDLE: begin
            if (issue && !dmem_ack) state_d = MEM_STATE_WAIT;
         end
         MEM_STATE_WAIT: begin
            if (dmem_ack)                state_d = MEM_STATE_IDLE;
            else if (cnt_q == TMO_LAST)  state_d = MEM_STATE_ABORT;
            else                         cnt_d   = cnt_q + 8'd1;
         end
         MEM_STATE_ABORT: state_d = MEM_STATE_IDLE;
         default:         state_d = MEM_STATE_IDLE;
      endcase
   end

   // FSM outputs: request level and upstream stall
   always_comb begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
      case (state_q)
         MEM_STATE_IDLE: begin
            dmem_req  = issue;
            mem_stall = issue & ~dmem_ack;
         end
         MEM_STATE_WAIT: begin
            dmem_req  = clr_n;
            mem_stall = clr_n & ~dmem_ack;
         end
         MEM_STATE_ABORT: mem_stall = clr_n;
         default: ;
      endcase
   end

   assign dmem_we    = dmem_req & mem_wr;
   assign dmem_addr  = {alu_result[31:2], 2'b00};
   assign dmem_be    = dmem_req ? lane_be : 4'b0000;
   assign dmem_wdata = lane_wdata;

   // Write-back value selection; zero when nothing is written
   always_comb begin
      wb_val = alu_result;
      case (wb_src)
         REG_WRITE_SRC_ALU:  wb_val = alu_result;
         REG_WRITE_SRC_MEM:  wb_val = load_val;
         REG_WRITE_SRC_LINK: wb_val = current_pc_ex + 32'd4;
         default:            wb_val = alu_result;
      endcase
      if (!reg_write_en) wb_val = '0;
   end

   // Stalled or misaligned instructions must not be forwarded or written back
   assign bubble_sel              = mem_stall | misalign;
   assign reg_write_data_realtime = wb_val;
   assign reg_write_num_realtime  = (bubble_sel || !reg_write_en) ? 5'd0 : reg_write_num;

   // WB pipeline latch: real instruction or bubble
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         current_pc_mem     <= '0;
         ins_mem            <= '0;
         controls_mem       <= CON_NOP;
         reg_write_data_mem <= '0;
         reg_write_en_mem   <= 1'b0;
         reg_write_num_mem  <= '0;
      end else if (bubble_sel) begin
         current_pc_mem     <= '0;
         ins_mem            <= '0;
         controls_mem       <= CON_NOP;
         reg_write_data_mem <= '0;
         reg_write_en_mem   <= 1'b0;
         reg_write_num_mem  <= '0;
      end else begin
         current_pc_mem     <= current_pc_ex;
         ins_mem            <= ins_ex;
         controls_mem       <= controls_ex;
         reg_write_data_mem <= wb_val;
         reg_write_en_mem   <= reg_write_en;
         reg_write_num_mem  <= reg_write_en ? reg_write_num : 5'd0;
      end
   end

   // Sticky error flags
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         mem_align_err <= 1'b0;
         mem_bus_err   <= 1'b0;
      end else begin
         if (misalign)                    mem_align_err <= 1'b1;
         if (state_q == MEM_STATE_ABORT)  mem_bus_err   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_mem.sv
// Directed bench for cpu_mem: zero-wait and multi-cycle loads, store packing,
// misalignment, timeout abort, link write-back and reset during WAIT.
module tb_cpu_mem;
   import cpu_mem_pkg::*;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [31:0] current_pc_ex, ins_ex, reg_read2_data_ex, alu_result;
   con_t        controls_ex;
   logic        reg_write_en;
   logic [4:0]  reg_write_num;
   logic        dmem_req, dmem_we, dmem_ack, mem_stall;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] current_pc_mem, ins_mem, reg_write_data_mem, reg_write_data_realtime;
   con_t        controls_mem;
   logic        reg_write_en_mem, mem_align_err, mem_bus_err;
   logic [4:0]  reg_write_num_mem, reg_write_num_realtime;

   int checks = 0;
   int errors = 0;

   cpu_mem #(.TIMEOUT(16)) dut (
      .clk(clk), .clr_n(clr_n),
      .current_pc_ex(current_pc_ex), .ins_ex(ins_ex), .controls_ex(controls_ex),
      .reg_read2_data_ex(reg_read2_data_ex), .alu_result(alu_result),
      .reg_write_en(reg_write_en), .reg_write_num(reg_write_num),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .mem_stall(mem_stall),
      .current_pc_mem(current_pc_mem), .ins_mem(ins_mem), .controls_mem(controls_mem),
      .reg_write_data_mem(reg_write_data_mem), .reg_write_en_mem(reg_write_en_mem),
      .reg_write_num_mem(reg_write_num_mem),
      .reg_write_num_realtime(reg_write_num_realtime),
      .reg_write_data_realtime(reg_write_data_realtime),
      .mem_align_err(mem_align_err), .mem_bus_err(mem_bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input con_t con,
                        input logic [31:0] rt, input logic [31:0] alu,
                        input logic en, input logic [4:0] num);
      current_pc_ex     = pc;
      ins_ex            = ins;
      controls_ex       = con;
      reg_read2_data_ex = rt;
      alu_result        = alu;
      reg_write_en      = en;
      reg_write_num     = num;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   con_t c_lw, c_lb, c_lbu, c_sh, c_alu, c_jal;
   int   nst, nab, nreq;
   logic aborted;

   initial begin
      c_lw  = mk_con(1'b1, 1'b0, MEM_SIZE_W, 1'b0, REG_WRITE_SRC_MEM);
      c_lb  = mk_con(1'b1, 1'b0, MEM_SIZE_B, 1'b1, REG_WRITE_SRC_MEM);
      c_lbu = mk_con(1'b1, 1'b0, MEM_SIZE_B, 1'b0, REG_WRITE_SRC_MEM);
      c_sh  = mk_con(1'b0, 1'b1, MEM_SIZE_H, 1'b0, REG_WRITE_SRC_ALU);
      c_alu = mk_con(1'b0, 1'b0, MEM_SIZE_W, 1'b0, REG_WRITE_SRC_ALU);
      c_jal = mk_con(1'b0, 1'b0, MEM_SIZE_W, 1'b0, REG_WRITE_SRC_LINK);

      // Reset with a load sitting in EX: no request may escape
      clr_n = 1'b0;
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      drive(32'h8, 32'h8C01_0000, c_lw, 32'h0, 32'h0, 1'b1, 5'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'b0, dmem_req}, 32'd0);
      chk("rst_stall", {31'b0, mem_stall}, 32'd0);
      chk("rst_con", 32'(controls_mem), 32'(CON_NOP));
      chk("rst_data", reg_write_data_mem, 32'h0);
      chk("rst_en", {31'b0, reg_write_en_mem}, 32'd0);
      chk("rst_errs", {30'b0, mem_align_err, mem_bus_err}, 32'd0);
      drive(32'h0, 32'h0, CON_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      clr_n = 1'b1;
      tick();

      // 1. lw zero-wait
      drive(32'h10, 32'h8C05_0100, c_lw, 32'h0, 32'h100, 1'b1, 5'd5);
      dmem_ack = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("lw_req", {31'b0, dmem_req}, 32'd1);
      chk("lw_we", {31'b0, dmem_we}, 32'd0);
      chk("lw_addr", dmem_addr, 32'h100);
      chk("lw_be", {28'b0, dmem_be}, 32'hF);
      chk("lw_stall", {31'b0, mem_stall}, 32'd0);
      chk("lw_rt_num", {27'b0, reg_write_num_realtime}, 32'd5);
      tick();
      chk("lw_wb", reg_write_data_mem, 32'hDEAD_BEEF);
      chk("lw_num", {27'b0, reg_write_num_mem}, 32'd5);
      chk("lw_ins", ins_mem, 32'h8C05_0100);

      // 2. lb signed at 0x103, ack on the fourth cycle
      drive(32'h14, 32'h8006_0103, c_lb, 32'h0, 32'h103, 1'b1, 5'd6);
      dmem_ack = 1'b0;
      dmem_rdata = 32'h80FF_0000;
      #1;
      chk("lb_be", {28'b0, dmem_be}, 32'h8);
      chk("lb_addr", dmem_addr, 32'h100);
      for (int i = 0; i < 3; i++) begin
         chk("lb_stall", {31'b0, mem_stall}, 32'd1);
         chk("lb_req", {31'b0, dmem_req}, 32'd1);
         tick();
         chk("lb_bubble", {31'b0, reg_write_en_mem}, 32'd0);
      end
      dmem_ack = 1'b1;
      #1;
      chk("lb_ack_stall", {31'b0, mem_stall}, 32'd0);
      chk("lb_ack_req", {31'b0, dmem_req}, 32'd1);
      tick();
      chk("lb_wb", reg_write_data_mem, 32'hFFFF_FF80);
      chk("lb_en", {31'b0, reg_write_en_mem}, 32'd1);

      // lbu, same address and data, zero-wait
      drive(32'h18, 32'h9006_0103, c_lbu, 32'h0, 32'h103, 1'b1, 5'd6);
      #1;
      tick();
      chk("lbu_wb", reg_write_data_mem, 32'h0000_0080);

      // 3. sh at 0x102
      drive(32'h1C, 32'hA404_0102, c_sh, 32'h1234_ABCD, 32'h102, 1'b0, 5'd0);
      #1;
      chk("sh_we", {31'b0, dmem_we}, 32'd1);
      chk("sh_be", {28'b0, dmem_be}, 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      chk("sh_addr", dmem_addr, 32'h100);
      tick();
      chk("sh_en", {31'b0, reg_write_en_mem}, 32'd0);
      chk("sh_num", {27'b0, reg_write_num_mem}, 32'd0);
      chk("sh_con", 32'(controls_mem), 32'(c_sh));

      // 4. misaligned lw
      drive(32'h20, 32'h8C07_0101, c_lw, 32'h0, 32'h101, 1'b1, 5'd7);
      dmem_ack = 1'b0;
      #1;
      chk("mis_req", {31'b0, dmem_req}, 32'd0);
      chk("mis_stall", {31'b0, mem_stall}, 32'd0);
      tick();
      chk("mis_flag", {31'b0, mem_align_err}, 32'd1);
      chk("mis_en", {31'b0, reg_write_en_mem}, 32'd0);
      chk("mis_con", 32'(controls_mem), 32'(CON_NOP));
      chk("mis_ins", ins_mem, 32'h0);
      drive(32'h24, 32'h0043_1820, c_alu, 32'h0, 32'h55, 1'b1, 5'd3);
      tick();
      chk("mis_sticky", {31'b0, mem_align_err}, 32'd1);
      chk("alu_wb", reg_write_data_mem, 32'h55);
      chk("alu_num", {27'b0, reg_write_num_mem}, 32'd3);

      // 5. lw never acknowledged: 1 issue + 16 WAIT + 1 ABORT stall cycles
      drive(32'h28, 32'h8C08_0200, c_lw, 32'h0, 32'h200, 1'b1, 5'd8);
      #1;
      nst = 0; nab = 0; nreq = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mem_stall) break;
         nst++;
         if (dmem_req) nreq++;
         aborted = !dmem_req;
         tick();
         if (aborted) begin
            nab++;
            drive(32'h2C, 32'h0, CON_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
            #1;
            break;
         end
      end
      chk("tmo_stall_cycles", 32'(nst), 32'd18);
      chk("tmo_req_cycles", 32'(nreq), 32'd17);
      chk("tmo_abort_cycles", 32'(nab), 32'd1);
      chk("tmo_bus_err", {31'b0, mem_bus_err}, 32'd1);
      chk("tmo_stall_drop", {31'b0, mem_stall}, 32'd0);
      chk("tmo_bubble", {31'b0, reg_write_en_mem}, 32'd0);

      // 6. jal link value
      drive(32'h40, 32'h0C00_0100, c_jal, 32'h0, 32'h0, 1'b1, 5'd31);
      #1;
      chk("jal_rt", reg_write_data_realtime, 32'h44);
      tick();
      chk("jal_wb", reg_write_data_mem, 32'h44);
      chk("jal_num", {27'b0, reg_write_num_mem}, 32'd31);
      chk("jal_pc", current_pc_mem, 32'h40);

      // Reset asserted while a load is waiting
      drive(32'h44, 32'h8C09_0300, c_lw, 32'h0, 32'h300, 1'b1, 5'd9);
      #1;
      tick();
      tick();
      chk("wait_req", {31'b0, dmem_req}, 32'd1);
      chk("wait_stall", {31'b0, mem_stall}, 32'd1);
      clr_n = 1'b0;
      #1;
      chk("arst_req", {31'b0, dmem_req}, 32'd0);
      chk("arst_stall", {31'b0, mem_stall}, 32'd0);
      chk("arst_data", reg_write_data_mem, 32'h0);
      chk("arst_num", {27'b0, reg_write_num_mem}, 32'd0);
      chk("arst_pc", current_pc_mem, 32'h0);
      chk("arst_errs", {30'b0, mem_align_err, mem_bus_err}, 32'd0);
      drive(32'h0, 32'h0, CON_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      tick();
      clr_n = 1'b1;
      tick();
      chk("post_rst_stall", {31'b0, mem_stall}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute runtime bound
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
